frame_sequencer: RTL and testbench

- Controller that sequences one image frame through the byte-stream parser: arms the parser, meters exactly 4 header bytes plus 3*H*W payload bytes out of the byte source, then stops.
- Snoops the source bytes to capture height and width itself, and rejects bad dimensions before any payload byte is released.
- Generates per-pixel coordinates and frame/line markers aligned with the parser's sample strobe, and cross-checks that alignment.
- Sits between the frame byte source (FIFO or UART buffer) and the parser; downstream pixel consumers use its markers.

---
 rtl/frame_pkg.sv | 33 +++
 rtl/frame_sequencer_pixel_coord_counter.sv | 63 ++++++
 rtl/frame_sequencer.sv | 179 +++++++++++++++++
 tb/tb_frame_sequencer.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_pkg.sv
// Shared definitions for the frame sequencer: FSM state encoding, frame
// geometry constants, header byte offsets and the dimension legality check.
package frame_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_HEADER,
        ST_PIXELS,
        ST_DONE
    } state_t;

    // Frame geometry: a 4-byte header followed by 3 bytes (R, G, B) per pixel.
    localparam int HDR_BYTES     = 4;
    localparam int BYTES_PER_PIX = 3;

    // Position of each header field in the byte stream.
    localparam logic [1:0] HDR_H_LO = 2'd0;
    localparam logic [1:0] HDR_H_HI = 2'd1;
    localparam logic [1:0] HDR_W_LO = 2'd2;
    localparam logic [1:0] HDR_W_HI = HDR_BYTES[1:0] - 2'd1;

    // Byte phase on which a pixel is complete (the blue byte).
    localparam logic [1:0] LAST_PHASE = BYTES_PER_PIX[1:0] - 2'd1;

    // A dimension pair is usable when both sides are non-zero and within range.
    function automatic logic dims_ok(input logic [15:0] h,
                                     input logic [15:0] w,
                                     input logic [15:0] max_dim);
        return (h != 16'd0) && (w != 16'd0) && (h <= max_dim) && (w <= max_dim);
    endfunction

endpackage

// File: rtl/frame_sequencer_pixel_coord_counter.sv
// Pixel coordinate generator: tracks the byte phase within a pixel and the
// (x, y) position, and flags the first pixel, end of line and last pixel.
module pixel_coord_counter
    import frame_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        i_clear,
    input  logic        i_step,
    input  logic [15:0] i_width,
    input  logic [15:0] i_height,
    output logic [15:0] o_x,
    output logic [15:0] o_y,
    output logic        o_pix_end,
    output logic        o_sof,
    output logic        o_eol,
    output logic        o_eof
);

    logic [1:0]  r_phase;
    logic [15:0] r_x;
    logic [15:0] r_y;
    logic        w_eol;
    logic        w_last_row;

    // Dimensions are known non-zero here, so the minus-one never underflows.
    assign w_eol      = (r_x == i_width - 16'd1);
    assign w_last_row = (r_y == i_height - 16'd1);

    assign o_x       = r_x;
    assign o_y       = r_y;
    assign o_pix_end = (r_phase == LAST_PHASE);
    assign o_sof     = (r_x == 16'd0) && (r_y == 16'd0);
    assign o_eol     = w_eol;
    assign o_eof     = w_eol && w_last_row;

    // Advance one byte per step; on the blue byte move to the next pixel.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_phase <= 2'd0;
            r_x     <= 16'd0;
            r_y     <= 16'd0;
        end else if (i_clear) begin
            r_phase <= 2'd0;
            r_x     <= 16'd0;
            r_y     <= 16'd0;
        end else if (i_step) begin
            // NOTE: non-blocking assignments so every register sees pre-edge values.
            if (o_pix_end) begin
                r_phase <= 2'd0;
                if (w_eol) begin
                    r_x <= 16'd0;
                    r_y <= r_y + 16'd1;
                end else begin
                    r_x <= r_x + 16'd1;
                end
            end else begin
                r_phase <= r_phase + 2'd1;
            end
        end
    end

endmodule

// File: rtl/frame_sequencer.sv
// Frame sequencer: arms the byte-stream parser, meters the header and the
// 3*H*W payload bytes out of the source, snoops the frame dimensions, and
// emits pixel coordinates and markers aligned with the parser's sample strobe.
module frame_sequencer
    import frame_pkg::*;
#(
    parameter logic [15:0] MAX_DIM = 16'd1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  src_data,
    output logic        src_en,
    output logic        parser_rst,
    input  logic        parser_sample,
    output logic        pix_valid,
    output logic [15:0] pix_x,
    output logic [15:0] pix_y,
    output logic        pix_sof,
    output logic        pix_eol,
    output logic        pix_eof,
    output logic [15:0] frame_height,
    output logic [15:0] frame_width,
    output logic        busy,
    output logic        frame_done,
    output logic        dim_err,
    output logic        sync_err
);

    state_t      r_state;
    logic [1:0]  r_hdr_cnt;
    logic        r_src_en;
    logic        r_parser_rst;
    logic        r_pix_valid;
    logic [15:0] r_pix_x;
    logic [15:0] r_pix_y;
    logic        r_pix_sof;
    logic        r_pix_eol;
    logic        r_pix_eof;
    logic [15:0] r_height;
    logic [15:0] r_width;
    logic        r_frame_done;
    logic        r_dim_err;
    logic        r_sync_err;

    logic [15:0] w_x;
    logic [15:0] w_y;
    logic        w_pix_end;
    logic        w_sof;
    logic        w_eol;
    logic        w_eof;
    logic        w_in_pixels;

    assign w_in_pixels = (r_state == ST_PIXELS);

    // Coordinates are held at zero outside PIXELS, so they start fresh each frame.
    pixel_coord_counter u_coord (
        .clk       (clk),
        .reset     (reset),
        .i_clear   (!w_in_pixels),
        .i_step    (w_in_pixels),
        .i_width   (r_width),
        .i_height  (r_height),
        .o_x       (w_x),
        .o_y       (w_y),
        .o_pix_end (w_pix_end),
        .o_sof     (w_sof),
        .o_eol     (w_eol),
        .o_eof     (w_eof)
    );

    // Frame FSM with registered outputs; src_en drops on the edge that takes the last byte.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_hdr_cnt    <= 2'd0;
            r_src_en     <= 1'b0;
            r_parser_rst <= 1'b0;
            r_pix_valid  <= 1'b0;
            r_pix_x      <= 16'd0;
            r_pix_y      <= 16'd0;
            r_pix_sof    <= 1'b0;
            r_pix_eol    <= 1'b0;
            r_pix_eof    <= 1'b0;
            r_height     <= 16'd0;
            r_width      <= 16'd0;
            r_frame_done <= 1'b0;
            r_dim_err    <= 1'b0;
            r_sync_err   <= 1'b0;
        end else begin
            // Strobes default low so each one lasts exactly one cycle.
            r_parser_rst <= 1'b0;
            r_pix_valid  <= 1'b0;
            r_pix_sof    <= 1'b0;
            r_pix_eol    <= 1'b0;
            r_pix_eof    <= 1'b0;
            r_frame_done <= 1'b0;

            // Our pixel strobe must coincide with the parser's, cycle for cycle.
            if ((r_state == ST_PIXELS || r_state == ST_DONE) &&
                (r_pix_valid != parser_sample)) begin
                r_sync_err <= 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state      <= ST_ARM;
                        r_src_en     <= 1'b1;
                        r_parser_rst <= 1'b1;
                        r_dim_err    <= 1'b0;
                        r_sync_err   <= 1'b0;
                    end
                end

                ST_ARM: begin
                    r_height[7:0] <= src_data;
                    r_hdr_cnt     <= HDR_H_HI;
                    r_state       <= ST_HEADER;
                end

                ST_HEADER: begin
                    r_hdr_cnt <= r_hdr_cnt + 2'd1;
                    case (r_hdr_cnt)
                        HDR_H_HI: r_height[15:8] <= src_data;
                        HDR_W_LO: r_width[7:0]   <= src_data;
                        default: begin
                            r_width[15:8] <= src_data;
                            if (dims_ok(r_height, {src_data, r_width[7:0]}, MAX_DIM)) begin
                                r_state <= ST_PIXELS;
                            end else begin
                                r_dim_err    <= 1'b1;
                                r_src_en     <= 1'b0;
                                r_frame_done <= 1'b1;
                                r_state      <= ST_DONE;
                            end
                        end
                    endcase
                end

                ST_PIXELS: begin
                    if (w_pix_end) begin
                        r_pix_valid <= 1'b1;
                        r_pix_x     <= w_x;
                        r_pix_y     <= w_y;
                        r_pix_sof   <= w_sof;
                        r_pix_eol   <= w_eol;
                        r_pix_eof   <= w_eof;
                        if (w_eof) begin
                            r_src_en     <= 1'b0;
                            r_frame_done <= 1'b1;
                            r_state      <= ST_DONE;
                        end
                    end
                end

                ST_DONE: r_state <= ST_IDLE;

                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign src_en       = r_src_en;
    assign parser_rst   = r_parser_rst;
    assign pix_valid    = r_pix_valid;
    assign pix_x        = r_pix_x;
    assign pix_y        = r_pix_y;
    assign pix_sof      = r_pix_sof;
    assign pix_eol      = r_pix_eol;
    assign pix_eof      = r_pix_eof;
    assign frame_height = r_height;
    assign frame_width  = r_width;
    assign busy         = (r_state != ST_IDLE);
    assign frame_done   = r_frame_done;
    assign dim_err      = r_dim_err;
    assign sync_err     = r_sync_err;

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed bench for frame_sequencer: a byte source, a simple parser model
// that strobes after every third payload byte, and a negedge monitor that
// records pixel strobes for comparison against hand-computed tables.
module tb_frame_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  src_data;
    logic        src_en;
    logic        parser_rst;
    logic        parser_sample = 1'b0;
    logic        pix_valid;
    logic [15:0] pix_x;
    logic [15:0] pix_y;
    logic        pix_sof;
    logic        pix_eol;
    logic        pix_eof;
    logic [15:0] frame_height;
    logic [15:0] frame_width;
    logic        busy;
    logic        frame_done;
    logic        dim_err;
    logic        sync_err;

    always #5 clk = ~clk;

    frame_sequencer #(.MAX_DIM(16'd1024)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .src_data      (src_data),
        .src_en        (src_en),
        .parser_rst    (parser_rst),
        .parser_sample (parser_sample),
        .pix_valid     (pix_valid),
        .pix_x         (pix_x),
        .pix_y         (pix_y),
        .pix_sof       (pix_sof),
        .pix_eol       (pix_eol),
        .pix_eof       (pix_eof),
        .frame_height  (frame_height),
        .frame_width   (frame_width),
        .busy          (busy),
        .frame_done    (frame_done),
        .dim_err       (dim_err),
        .sync_err      (sync_err)
    );

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Byte source: header bytes first, then an arbitrary payload pattern.
    logic [7:0]  hdr [0:3];
    int unsigned n_consumed = 0;
    int unsigned base       = 0;
    int unsigned idx;

    always_comb begin
        idx      = n_consumed - base;
        src_data = (idx < 4) ? hdr[idx[1:0]] : idx[7:0] ^ 8'h5A;
    end

    always @(posedge clk) begin
        if (src_en) n_consumed <= n_consumed + 1;
    end

    // Parser model: byte 0 lands at count 0 under parser_rst; strobes the cycle after each blue byte.
    int unsigned pcnt   = 0;
    bit          inject = 1'b0;
    always @(posedge clk) begin : parser_model
        int unsigned e;
        e = parser_rst ? 0 : pcnt;
        if (src_en) pcnt <= e + 1;
        parser_sample <= !inject && src_en && (e >= 4) && ((e - 4) % 3 == 2);
    end

    // Monitor: record every pixel strobe and count pulses.
    int unsigned n_pix  = 0;
    int unsigned n_done = 0;
    int unsigned n_prst = 0;
    logic [15:0] rec_x [0:255];
    logic [15:0] rec_y [0:255];
    logic [2:0]  rec_f [0:255];
    always @(negedge clk) begin
        if (pix_valid) begin
            rec_x[n_pix[7:0]] <= pix_x;
            rec_y[n_pix[7:0]] <= pix_y;
            rec_f[n_pix[7:0]] <= {pix_sof, pix_eol, pix_eof};
            n_pix <= n_pix + 1;
        end
        if (frame_done) n_done <= n_done + 1;
        if (parser_rst) n_prst <= n_prst + 1;
    end

    // Expected strobes; flags are {sof, eol, eof}.
    int         e23_x [6] = '{0, 1, 2, 0, 1, 2};
    int         e23_y [6] = '{0, 0, 0, 1, 1, 1};
    logic [2:0] e23_f [6] = '{3'b100, 3'b000, 3'b010, 3'b000, 3'b000, 3'b011};
    int         e22_x [4] = '{0, 1, 0, 1};
    int         e22_y [4] = '{0, 0, 1, 1};
    logic [2:0] e22_f [4] = '{3'b100, 3'b010, 3'b000, 3'b011};

    int unsigned s_cons, s_pix, s_done, s_prst;

    task automatic begin_frame(input logic [7:0] b0, input logic [7:0] b1,
                               input logic [7:0] b2, input logic [7:0] b3);
        @(negedge clk);
        hdr[0] = b0; hdr[1] = b1; hdr[2] = b2; hdr[3] = b3;
        base   = n_consumed;
        s_cons = n_consumed;
        s_pix  = n_pix;
        s_done = n_done;
        s_prst = n_prst;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            if (frame_done) ok = 1'b1;
            else @(negedge clk);
        end
        check({tag, "_done_seen"}, 32'(ok), 1);
    endtask

    task automatic run_frame(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input logic [7:0] b3, input int budget);
        begin_frame(b0, b1, b2, b3);
        wait_done(tag, budget);
        @(negedge clk);
    endtask

    task automatic check_pix(input string tag, input int k, input int x, input int y,
                             input logic [2:0] f);
        int unsigned j;
        j = (s_pix + k) & 255;
        check($sformatf("%s_x%0d", tag, k), 32'(rec_x[j]), x);
        check($sformatf("%s_y%0d", tag, k), 32'(rec_y[j]), y);
        check($sformatf("%s_flags%0d", tag, k), 32'(rec_f[j]), 32'(f));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        start = 1'b0;
        hdr[0] = 8'h00; hdr[1] = 8'h00; hdr[2] = 8'h00; hdr[3] = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_src_en", 32'(src_en), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_parser_rst", 32'(parser_rst), 0);
        check("rst_pix_valid", 32'(pix_valid), 0);
        check("rst_frame_done", 32'(frame_done), 0);
        check("rst_height", 32'(frame_height), 0);
        check("rst_width", 32'(frame_width), 0);
        check("rst_dim_err", 32'(dim_err), 0);
        check("rst_sync_err", 32'(sync_err), 0);
        reset = 1'b1;

        // 2 rows x 3 columns
        run_frame("f2x3", 8'h02, 8'h00, 8'h03, 8'h00, 200);
        check("f2x3_bytes", n_consumed - s_cons, 22);
        check("f2x3_strobes", n_pix - s_pix, 6);
        check("f2x3_done_pulses", n_done - s_done, 1);
        check("f2x3_prst_pulses", n_prst - s_prst, 1);
        check("f2x3_height", 32'(frame_height), 2);
        check("f2x3_width", 32'(frame_width), 3);
        check("f2x3_dim_err", 32'(dim_err), 0);
        check("f2x3_sync_err", 32'(sync_err), 0);
        check("f2x3_busy_after", 32'(busy), 0);
        for (int k = 0; k < 6; k++) check_pix("f2x3", k, e23_x[k], e23_y[k], e23_f[k]);

        // 1x1: a single strobe carrying all three markers
        run_frame("f1x1", 8'h01, 8'h00, 8'h01, 8'h00, 100);
        check("f1x1_bytes", n_consumed - s_cons, 7);
        check("f1x1_strobes", n_pix - s_pix, 1);
        check_pix("f1x1", 0, 0, 0, 3'b111);
        check("f1x1_sync_err", 32'(sync_err), 0);

        // Parser strobe suppressed: misalignment must be flagged and stay set
        inject = 1'b1;
        run_frame("fsync", 8'h01, 8'h00, 8'h01, 8'h00, 100);
        inject = 1'b0;
        check("fsync_sync_err", 32'(sync_err), 1);
        repeat (2) @(negedge clk);
        check("fsync_sticky", 32'(sync_err), 1);

        // Width 0: rejected after the header, no payload released
        run_frame("fw0", 8'h05, 8'h00, 8'h00, 8'h00, 100);
        check("fw0_bytes", n_consumed - s_cons, 4);
        check("fw0_dim_err", 32'(dim_err), 1);
        check("fw0_done_pulses", n_done - s_done, 1);
        check("fw0_strobes", n_pix - s_pix, 0);
        check("fw0_height", 32'(frame_height), 5);
        check("fw0_sync_cleared", 32'(sync_err), 0);

        // Height 1025 exceeds MAX_DIM
        run_frame("fh1025", 8'h01, 8'h04, 8'h02, 8'h00, 100);
        check("fh1025_bytes", n_consumed - s_cons, 4);
        check("fh1025_dim_err", 32'(dim_err), 1);
        check("fh1025_strobes", n_pix - s_pix, 0);

        // Next valid start clears dim_err as soon as it is accepted
        begin_frame(8'h01, 8'h00, 8'h02, 8'h00);
        check("f1x2_dim_err_cleared", 32'(dim_err), 0);
        check("f1x2_busy", 32'(busy), 1);
        wait_done("f1x2", 100);
        @(negedge clk);
        check("f1x2_bytes", n_consumed - s_cons, 10);
        check("f1x2_strobes", n_pix - s_pix, 2);
        check("f1x2_dim_err", 32'(dim_err), 0);

        // Height exactly MAX_DIM is legal
        run_frame("fmax", 8'h00, 8'h04, 8'h01, 8'h00, 4000);
        check("fmax_dim_err", 32'(dim_err), 0);
        check("fmax_bytes", n_consumed - s_cons, 3076);
        check("fmax_strobes", n_pix - s_pix, 1024);
        check_pix("fmax", 1023, 0, 1023, 3'b011);
        check("fmax_sync_err", 32'(sync_err), 0);

        // start pulsed during PIXELS and during DONE is ignored
        begin_frame(8'h02, 8'h00, 8'h02, 8'h00);
        for (int i = 0; i < 100 && (n_pix - s_pix) < 1; i++) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("fstart", 100);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("fstart_busy", 32'(busy), 0);
        check("fstart_src_en", 32'(src_en), 0);
        check("fstart_bytes", n_consumed - s_cons, 16);
        check("fstart_strobes", n_pix - s_pix, 4);
        check("fstart_done_pulses", n_done - s_done, 1);
        for (int k = 0; k < 4; k++) check_pix("fstart", k, e22_x[k], e22_y[k], e22_f[k]);

        // Reset mid-PIXELS, then a clean 2x2 frame
        begin_frame(8'h02, 8'h00, 8'h03, 8'h00);
        for (int i = 0; i < 100 && (n_pix - s_pix) < 2; i++) @(negedge clk);
        check("frst_mid_busy", 32'(busy), 1);
        reset = 1'b0;
        #1;
        check("frst_src_en", 32'(src_en), 0);
        check("frst_pix_valid", 32'(pix_valid), 0);
        check("frst_busy", 32'(busy), 0);
        @(negedge clk);
        reset = 1'b1;
        run_frame("fpost", 8'h02, 8'h00, 8'h02, 8'h00, 200);
        check("fpost_bytes", n_consumed - s_cons, 16);
        check("fpost_strobes", n_pix - s_pix, 4);
        check("fpost_done_pulses", n_done - s_done, 1);
        check("fpost_sync_err", 32'(sync_err), 0);
        for (int k = 0; k < 4; k++) check_pix("fpost", k, e22_x[k], e22_y[k], e22_f[k]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
